round_ctrl: RTL and testbench
=============================

// Module: round_ctrl
// PURPOSE
//  Game-round sequencer and damage scheduler for the health-bar datapath.
//  - Converts raw collision requests into single-cycle hit_cat/hit_dog pulses,
//    rate-limited by a per-player invulnerability cooldown counted in frames.
//  - Pulses reset_hp at round start and detects KO from hp_cat/hp_dog.
//  - Runs the IDLE/FIGHT/KO round FSM for the top level.
// PARAMETERS
//  COOLDOWN_FRAMES  30  frames a player is immune after taking a hit (1..255)
//  KO_FRAMES        180 frames the KO state is held before returning to IDLE (1..1023)
//  SETTLE_CYCLES    2   clk cycles after reset_hp during which KO detection is masked
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous, active-high reset
//  frame_tick   in   1   one-cycle pulse per frame (vsync start)
//  start        in   1   start request (level or pulse); rising edge used
//  hit_req_cat  in   1   collision on cat (level); rising edge = one hit request
//  hit_req_dog  in   1   collision on dog (level); rising edge = one hit request
//  hp_cat       in   10  current cat health, 0..500
//  hp_dog       in   10  current dog health, 0..500
//  hit_cat      out  1   one-cycle damage pulse to the health datapath
//  hit_dog      out  1   one-cycle damage pulse to the health datapath
//  reset_hp     out  1   one-cycle health-restore pulse
//  state        out  2   0=IDLE 1=FIGHT 2=KO
//  winner       out  2   0=none 1=cat 2=dog 3=draw
//  immune_cat   out  1   cat cooldown counter non-zero
//  immune_dog   out  1   dog cooldown counter non-zero
// BEHAVIOUR
//  Reset: state=IDLE, winner=0, all pulses 0, cooldowns 0, edge-detect regs 0. All outputs registered.
//  Reset mid-round aborts at once; no reset_hp pulse is issued by rst itself.
//  Edge detect: prev regs sample the inputs each cycle; rise = in & ~prev.
//  IDLE:
//   - start rise -> FIGHT next cycle, with reset_hp=1 for that cycle.
//   - winner is cleared and both cooldowns are zeroed on that transition.
//  FIGHT:
//   - Cat hit: rise on hit_req_cat at cycle N with cooldown_cat==0 gives hit_cat=1 at N+1.
//     cooldown_cat is loaded to COOLDOWN_FRAMES at N+1.
//   - Dog hit: identical, using hit_req_dog, hit_dog and cooldown_dog.
//   - A rise while cooldown is non-zero is dropped; it is not queued.
//   - Cat and dog hits are independent. Both may pulse in the same cycle.
//   - Cooldowns are 8-bit. They decrement by 1 on frame_tick and saturate at 0.
//     If a load and a frame_tick coincide, the load wins.
//   - KO check runs every cycle once the settle counter has reached SETTLE_CYCLES.
//     The settle counter is reset on FIGHT entry and is also masked for 1 cycle after any hit pulse.
//   - KO result: hp_cat==0 & hp_dog==0 -> winner=3; hp_dog==0 -> winner=1; hp_cat==0 -> winner=2.
//     state goes to KO on the next cycle. No hit pulses are issued once in KO.
//   - start is ignored in FIGHT.
//  KO:
//   - A 10-bit frame counter is cleared on entry and increments on frame_tick.
//   - The counter reaching KO_FRAMES -> IDLE. winner is held until the next start.
//   - start and hit requests are ignored in KO.
//  immune_x = (cooldown_x != 0), registered together with the counter.
// TESTING
//  1. rst, then start pulse -> reset_hp=1 for exactly 1 cycle; state=1 next cycle; winner=0.
//  2. FIGHT, hit_req_cat held high 50 cycles -> exactly one hit_cat pulse at edge+1.
//     immune_cat=1 for 30 frame_ticks, then 0.
//  3. Second cat rise at frame 10 of cooldown -> no hit_cat. Rise after 30 frame_ticks -> hit_cat pulse.
//  4. Simultaneous rises on both requests, cooldowns 0 -> hit_cat and hit_dog high in the same cycle.
//  5. Model hp_dog stepping 500->0 over 10 hits -> state=2, winner=1.
//     Further hit requests give no pulses. After 180 frame_ticks state=0 and winner stays 1.
//  6. hp_cat=hp_dog=0 on start (stale) -> no false KO during the settle window.
//     Both at 0 later in the same cycle -> winner=3. rst asserted mid-KO -> state=0, winner=0 next cycle.

Source files
------------

// File: rtl/round_ctrl_if.sv
// rtl/round_ctrl_if.sv - round sequencer control/status bundle
interface round_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       hit_req_cat;
  logic       hit_req_dog;
  logic [9:0] hp_cat;
  logic [9:0] hp_dog;
  logic       hit_cat;
  logic       hit_dog;
  logic       reset_hp;
  logic [1:0] state;
  logic [1:0] winner;
  logic       immune_cat;
  logic       immune_dog;

  modport master (
    output frame_tick, start, hit_req_cat, hit_req_dog, hp_cat, hp_dog,
    input  hit_cat, hit_dog, reset_hp, state, winner, immune_cat, immune_dog
  );

  modport slave (
    input  frame_tick, start, hit_req_cat, hit_req_dog, hp_cat, hp_dog,
    output hit_cat, hit_dog, reset_hp, state, winner, immune_cat, immune_dog
  );
endinterface

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - round FSM, hit pulse scheduler with per-player cooldown, KO detect
module round_ctrl #(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int KO_FRAMES       = 180,
  parameter int SETTLE_CYCLES   = 2
) (
  input logic        clk,
  input logic        rst,
  round_ctrl_if.slave bus
);
  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [1:0]  winner_q, winner_n;
  logic        hit_cat_q, hit_cat_n;
  logic        hit_dog_q, hit_dog_n;
  logic        reset_hp_q, reset_hp_n;
  logic [7:0]  cd_cat_q, cd_cat_n;
  logic [7:0]  cd_dog_q, cd_dog_n;
  logic        immune_cat_q, immune_dog_q;
  logic [SW-1:0] settle_q, settle_n;
  logic [9:0]  ko_cnt_q, ko_cnt_n;
  logic [9:0]  ko_inc;
  logic        start_prev, cat_prev, dog_prev;
  logic        start_rise, cat_rise, dog_rise;
  logic        ko_armed;
  logic        hp_cat_zero, hp_dog_zero;

  assign start_rise  = bus.start & ~start_prev;
  assign cat_rise    = bus.hit_req_cat & ~cat_prev;
  assign dog_rise    = bus.hit_req_dog & ~dog_prev;
  assign hp_cat_zero = (bus.hp_cat == 10'd0);
  assign hp_dog_zero = (bus.hp_dog == 10'd0);
  assign ko_inc      = ko_cnt_q + 10'd1;

  // hp is stale right after restore and during the cycle a hit is being applied
  assign ko_armed = (settle_q == SW'(SETTLE_CYCLES)) && !hit_cat_q && !hit_dog_q;

  always_comb begin
    state_n    = state_q;
    winner_n   = winner_q;
    hit_cat_n  = 1'b0;
    hit_dog_n  = 1'b0;
    reset_hp_n = 1'b0;
    settle_n   = settle_q;
    ko_cnt_n   = ko_cnt_q;
    cd_cat_n   = (bus.frame_tick && cd_cat_q != 8'd0) ? cd_cat_q - 8'd1 : cd_cat_q;
    cd_dog_n   = (bus.frame_tick && cd_dog_q != 8'd0) ? cd_dog_q - 8'd1 : cd_dog_q;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_n    = FIGHT;
          reset_hp_n = 1'b1;
          winner_n   = 2'd0;
          cd_cat_n   = 8'd0;
          cd_dog_n   = 8'd0;
          settle_n   = '0;
        end
      end
      FIGHT: begin
        if (settle_q != SW'(SETTLE_CYCLES))
          settle_n = settle_q + SW'(1);
        if (ko_armed && (hp_cat_zero || hp_dog_zero)) begin
          state_n  = KO;
          ko_cnt_n = 10'd0;
          if (hp_cat_zero && hp_dog_zero) winner_n = 2'd3;
          else if (hp_dog_zero)           winner_n = 2'd1;
          else                            winner_n = 2'd2;
        end else begin
          if (cat_rise && cd_cat_q == 8'd0) begin
            hit_cat_n = 1'b1;
            cd_cat_n  = 8'(COOLDOWN_FRAMES);
          end
          if (dog_rise && cd_dog_q == 8'd0) begin
            hit_dog_n = 1'b1;
            cd_dog_n  = 8'(COOLDOWN_FRAMES);
          end
        end
      end
      KO: begin
        if (bus.frame_tick) begin
          ko_cnt_n = ko_inc;
          if (ko_inc == 10'(KO_FRAMES))
            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= 2'd0;
      hit_cat_q    <= 1'b0;
      hit_dog_q    <= 1'b0;
      reset_hp_q   <= 1'b0;
      cd_cat_q     <= 8'd0;
      cd_dog_q     <= 8'd0;
      immune_cat_q <= 1'b0;
      immune_dog_q <= 1'b0;
      settle_q     <= '0;
      ko_cnt_q     <= 10'd0;
      start_prev   <= 1'b0;
      cat_prev     <= 1'b0;
      dog_prev     <= 1'b0;
    end else begin
      state_q      <= state_n;
      winner_q     <= winner_n;
      hit_cat_q    <= hit_cat_n;
      hit_dog_q    <= hit_dog_n;
      reset_hp_q   <= reset_hp_n;
      cd_cat_q     <= cd_cat_n;
      cd_dog_q     <= cd_dog_n;
      immune_cat_q <= (cd_cat_n != 8'd0);
      immune_dog_q <= (cd_dog_n != 8'd0);
      settle_q     <= settle_n;
      ko_cnt_q     <= ko_cnt_n;
      start_prev   <= bus.start;
      cat_prev     <= bus.hit_req_cat;
      dog_prev     <= bus.hit_req_dog;
    end
  end

  assign bus.state      = state_q;
  assign bus.winner     = winner_q;
  assign bus.hit_cat    = hit_cat_q;
  assign bus.hit_dog    = hit_dog_q;
  assign bus.reset_hp   = reset_hp_q;
  assign bus.immune_cat = immune_cat_q;
  assign bus.immune_dog = immune_dog_q;
endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - directed self-checking bench for round_ctrl
module tb_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_ctrl_if bus();

  round_ctrl #(
    .COOLDOWN_FRAMES(30),
    .KO_FRAMES(180),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    int pulses;
    bus.frame_tick  = 1'b0;
    bus.start       = 1'b0;
    bus.hit_req_cat = 1'b0;
    bus.hit_req_dog = 1'b0;
    bus.hp_cat      = 10'd500;
    bus.hp_dog      = 10'd500;

    // reset state
    step(); step();
    rst = 1'b0;
    check("rst_state",  32'(bus.state), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_reset_hp", 32'(bus.reset_hp), 0);
    check("rst_hits", 32'({bus.hit_cat, bus.hit_dog}), 0);
    check("rst_immune", 32'({bus.immune_cat, bus.immune_dog}), 0);

    // 1: start held high gives a single reset_hp pulse
    bus.start = 1'b1;
    step();
    check("t1_reset_hp", 32'(bus.reset_hp), 1);
    check("t1_state", 32'(bus.state), 1);
    check("t1_winner", 32'(bus.winner), 0);
    step();
    check("t1_reset_hp_off", 32'(bus.reset_hp), 0);
    check("t1_state_hold", 32'(bus.state), 1);
    bus.start = 1'b0;

    // 2: long cat collision -> one hit, 30 frames immune
    bus.hit_req_cat = 1'b1;
    step();
    check("t2_hit_edge", 32'(bus.hit_cat), 1);
    check("t2_immune_on", 32'(bus.immune_cat), 1);
    pulses = 1;
    for (int i = 0; i < 49; i++) begin
      step();
      if (bus.hit_cat) pulses++;
    end
    check("t2_one_pulse", 32'(pulses), 1);
    bus.hit_req_cat = 1'b0;
    tick(29);
    check("t2_immune_29", 32'(bus.immune_cat), 1);
    tick(1);
    check("t2_immune_30", 32'(bus.immune_cat), 0);

    // 3: rise during cooldown dropped, rise after expiry accepted
    bus.hit_req_cat = 1'b1;
    step();
    check("t3_first", 32'(bus.hit_cat), 1);
    bus.hit_req_cat = 1'b0;
    tick(10);
    bus.hit_req_cat = 1'b1;
    step();
    check("t3_drop", 32'(bus.hit_cat), 0);
    check("t3_immune", 32'(bus.immune_cat), 1);
    bus.hit_req_cat = 1'b0;
    tick(20);
    check("t3_expired", 32'(bus.immune_cat), 0);
    bus.hit_req_cat = 1'b1;
    step();
    check("t3_after", 32'(bus.hit_cat), 1);
    bus.hit_req_cat = 1'b0;
    tick(30);

    // 4: simultaneous hits
    bus.hit_req_cat = 1'b1;
    bus.hit_req_dog = 1'b1;
    step();
    check("t4_both", 32'({bus.hit_cat, bus.hit_dog}), 3);
    bus.hit_req_cat = 1'b0;
    bus.hit_req_dog = 1'b0;
    tick(30);

    // 5: dog drained 500 -> 0 in 10 hits, cat wins
    for (int k = 1; k <= 10; k++) begin
      bus.hit_req_dog = 1'b1;
      step();
      check($sformatf("t5_hit_%0d", k), 32'(bus.hit_dog), 1);
      bus.hp_dog = 10'(500 - 50 * k);
      bus.hit_req_dog = 1'b0;
      if (k < 10) tick(30);
    end
    step();
    check("t5_mask", 32'(bus.state), 1);
    step();
    check("t5_ko_state", 32'(bus.state), 2);
    check("t5_ko_winner", 32'(bus.winner), 1);
    bus.hit_req_cat = 1'b1;
    bus.hit_req_dog = 1'b1;
    step();
    check("t5_no_hit_ko", 32'({bus.hit_cat, bus.hit_dog}), 0);
    bus.hit_req_cat = 1'b0;
    bus.hit_req_dog = 1'b0;
    tick(179);
    check("t5_ko_179", 32'(bus.state), 2);
    tick(1);
    check("t5_idle_180", 32'(bus.state), 0);
    check("t5_winner_held", 32'(bus.winner), 1);

    // 6: stale zero hp masked during settle, then draw, then rst mid-KO
    bus.hp_cat = 10'd0;
    bus.hp_dog = 10'd0;
    bus.start  = 1'b1;
    step();
    check("t6_start", 32'(bus.state), 1);
    check("t6_winner_clr", 32'(bus.winner), 0);
    check("t6_reset_hp", 32'(bus.reset_hp), 1);
    bus.start = 1'b0;
    step();
    check("t6_settle1", 32'(bus.state), 1);
    step();
    check("t6_settle2", 32'(bus.state), 1);
    bus.hp_cat = 10'd500;
    bus.hp_dog = 10'd500;
    step();
    check("t6_alive", 32'(bus.state), 1);
    bus.hp_cat = 10'd0;
    bus.hp_dog = 10'd0;
    step();
    check("t6_draw_state", 32'(bus.state), 2);
    check("t6_draw_winner", 32'(bus.winner), 3);
    rst = 1'b1;
    step();
    check("t6_rst_state", 32'(bus.state), 0);
    check("t6_rst_winner", 32'(bus.winner), 0);
    check("t6_rst_reset_hp", 32'(bus.reset_hp), 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
